// File: rtl/aes_decipher_arbiter.sv
// aes_decipher_arbiter: shares one AES decipher core between two requesters.
// Define AES_DEC_ARB_RR_EN for round-robin grants; otherwise requester 0 has fixed priority.
module aes_decipher_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_block,
    input  logic         req0_keylen,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_block,
    input  logic         req1_keylen,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp_block,
    output logic         core_next,
    output logic [127:0] core_block,
    output logic         core_keylen,
    input  logic         core_ready,
    input  logic [127:0] core_new_block,
    output logic         key_sel,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   wait_first;
    logic   accept;
    logic   grant_id;
    logic   rsp_done;

`ifdef AES_DEC_ARB_RR_EN
    logic rr_ptr;

    // The pointer only breaks ties; a lone requester is always served.
    assign grant_id = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
`else
    assign grant_id = !req0_valid;
`endif

    // Request handshake is combinational so the grant and the data capture share one cycle.
    assign accept     = !reset && (state == IDLE) && core_ready && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_first  <= 1'b0;
            core_next   <= 1'b0;
            core_block  <= '0;
            core_keylen <= 1'b0;
            key_sel     <= 1'b0;
            rsp_block   <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
`ifdef AES_DEC_ARB_RR_EN
            rr_ptr      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_block  <= grant_id ? req1_block  : req0_block;
                        core_keylen <= grant_id ? req1_keylen : req0_keylen;
                        key_sel     <= grant_id;
                        core_next   <= 1'b1;
                        state       <= ISSUE;
`ifdef AES_DEC_ARB_RR_EN
                        rr_ptr      <= ~rr_ptr;
`endif
                    end
                end
                ISSUE: begin
                    core_next  <= 1'b0;
                    wait_first <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    // core_ready may still show the pre-start idle value in the first cycle.
                    wait_first <= 1'b0;
                    if (!wait_first && core_ready) begin
                        rsp_block  <= core_new_block;
                        rsp0_valid <= !key_sel;
                        rsp1_valid <= key_sel;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decipher_arbiter.sv
// tb_aes_decipher_arbiter: scoreboard bench with a stub decipher core and a reference arbiter model.
module tb_aes_decipher_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req0_keylen;
    logic         req1_valid, req1_ready, req1_keylen;
    logic [127:0] req0_block, req1_block;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [127:0] rsp_block;
    logic         core_next, core_keylen, core_ready, key_sel, busy;
    logic [127:0] core_block, core_new_block;

    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct {
        logic         id;
        logic [127:0] blk;
        logic         kl;
        logic [127:0] res;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_next   = 0;
    int   n_accept = 0;
    int   ncyc     = 0;
    int   rise_cyc = -10;
    bit   hold_rsp = 1'b0;
    logic rr_model = 1'b0;

    aes_decipher_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_keylen(req0_keylen),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_keylen(req1_keylen),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_block(rsp_block), .core_next(core_next), .core_block(core_block), .core_keylen(core_keylen),
        .core_ready(core_ready), .core_new_block(core_new_block), .key_sel(key_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference decipher: FIPS-197 vectors map to their plaintext, anything else to a key-dependent mix.
    function automatic logic [127:0] decipher(input logic [127:0] blk, input logic kl, input logic id);
        if (blk == CT128 && !kl && !id) return PT;
        if (blk == CT256 && kl && id) return PT;
        return blk ^ (id ? (KEY1[255:128] ^ KEY1[127:0]) : KEY0) ^ {128{kl}};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    // Stub core: registered ready, variable latency, result from the reference decipher.
    logic [127:0] cap_blk;
    logic         cap_kl, cap_ks, cbusy;
    int           cnt;
    always @(posedge clk) begin
        if (reset) begin
            core_ready     <= 1'b1;
            cbusy          <= 1'b0;
            core_new_block <= '0;
            cnt            <= 0;
        end else if (core_next) begin
            core_ready <= 1'b0;
            cbusy      <= 1'b1;
            cnt        <= int'($urandom_range(2, 6));
            cap_blk    <= core_block;
            cap_kl     <= core_keylen;
            cap_ks     <= key_sel;
        end else if (cbusy) begin
            if (cnt == 1) begin
                core_ready     <= 1'b1;
                cbusy          <= 1'b0;
                core_new_block <= decipher(cap_blk, cap_kl, cap_ks);
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Monitor: drives response back-pressure and pops the scoreboard on each response handshake.
    initial begin
        logic prev_cr, prev_rv, prev_cn;
        exp_t e;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        prev_cr = 1'b1; prev_rv = 1'b0; prev_cn = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (reset) begin
                prev_cr = 1'b1; prev_rv = 1'b0; prev_cn = 1'b0;
                continue;
            end
            if (core_next) begin
                n_next++;
                checkOutput("core_next_pulse", prev_cn, 1'b0);
            end
            if (core_ready && !prev_cr && busy) rise_cyc = ncyc;
            if ((rsp0_valid || rsp1_valid) && !prev_rv) checkOutput("rsp_latency", ncyc, rise_cyc + 1);
            prev_cr = core_ready;
            prev_rv = rsp0_valid || rsp1_valid;
            prev_cn = core_next;
            rsp0_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
            rsp1_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rsp0_valid || rsp1_valid) begin
                checkOutput("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                    if (q.size() == 0) begin
                        failNow("rsp_unexpected");
                    end else begin
                        e = q.pop_front();
                        checkOutput("rsp_id", rsp1_valid, e.id);
                        checkOutput("rsp_block", rsp_block, e.res);
                        checkOutput("core_block_hold", core_block, e.blk);
                        checkOutput("core_keylen_hold", core_keylen, e.kl);
                        checkOutput("key_sel_hold", key_sel, e.id);
                    end
                end
            end
        end
    end

    // Presents a request and waits for its grant; the expected winner comes from the reference arbiter.
    task automatic applyStimulus(input logic v0, input logic v1, input logic [127:0] b0, input logic [127:0] b1,
                                 input logic k0, input logic k1, input bit keep, output int gid);
        bit   got = 1'b0;
        logic exp_id;
        exp_t e;
        gid = -1;
        @(negedge clk);
        req0_valid = v0; req0_block = b0; req0_keylen = k0;
        req1_valid = v1; req1_block = b1; req1_keylen = k1;
        for (int n = 0; n < 400 && !got; n++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got = 1'b1;
`ifdef AES_DEC_ARB_RR_EN
                exp_id = (v0 && v1) ? rr_model : v1;
                rr_model = ~rr_model;
`else
                exp_id = !v0;
`endif
                checkOutput("grant", {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
                gid    = int'(req1_ready);
                e.id   = exp_id;
                e.blk  = exp_id ? b1 : b0;
                e.kl   = exp_id ? k1 : k0;
                e.res  = decipher(e.blk, e.kl, exp_id);
                q.push_back(e);
                n_accept++;
                @(posedge clk);
                #1;
                if (!keep) begin
                    req0_valid = 1'b0; req1_valid = 1'b0;
                    req0_block = {4{$urandom}}; req1_block = {4{$urandom}};
                    req0_keylen = 1'($urandom); req1_keylen = 1'($urandom);
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!got) failNow("grant_timeout");
    endtask

    task automatic drain();
        int n = 0;
        while (n < 500 && (q.size() != 0 || busy)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) failNow("drain_timeout");
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        rr_model = 1'b0;
    endtask

    initial begin
        int   gid;
        int   grants[4];
        int   exp_seq[4];
        bit   stable_ok;
        int   n;
        logic [127:0] held;
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_block = '0; req1_block = '0; req0_keylen = 1'b0; req1_keylen = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_block", rsp_block, '0);
        checkOutput("reset_core_block", core_block, '0);
        checkOutput("reset_flags", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, core_next, core_keylen, key_sel, busy}, 8'h00);
        reset = 1'b0;

        $display("[TB] FIPS-197 single requests");
        applyStimulus(1'b1, 1'b0, CT128, '0, 1'b0, 1'b0, 1'b0, gid);
        applyStimulus(1'b0, 1'b1, '0, CT256, 1'b0, 1'b1, 1'b0, gid);
        drain();

        $display("[TB] response back-pressure");
        hold_rsp = 1'b1;
        applyStimulus(1'b1, 1'b0, {4{$urandom}}, '0, 1'($urandom), 1'b0, 1'b0, gid);
        n = 0;
        while (n < 100 && !(rsp0_valid || rsp1_valid)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) failNow("bp_rsp_timeout");
        held = rsp_block;
        req1_valid = 1'b1; req1_block = {4{$urandom}};
        stable_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (!rsp0_valid || rsp1_valid || rsp_block !== held || req0_ready || req1_ready || core_next)
                stable_ok = 1'b0;
        end
        checkOutput("backpressure_hold", stable_ok, 1'b1);
        req1_valid = 1'b0;
        hold_rsp = 1'b0;
        drain();

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 1'b1, '0, {4{$urandom}}, 1'b0, 1'($urandom), 1'b0, gid);
        @(negedge clk);
        @(negedge clk);
        checkOutput("in_wait_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        rr_model = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        applyStimulus(1'b1, 1'b0, CT128, '0, 1'b0, 1'b0, 1'b0, gid);
        drain();

        $display("[TB] simultaneous requests held high");
        pulseReset();
`ifdef AES_DEC_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, CT128, CT256, 1'b0, 1'b1, 1'b1, gid);
            grants[i] = gid;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) checkOutput("grant_order", grants[i], exp_seq[i]);
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            logic [1:0] pat;
            pat = 2'($urandom_range(1, 3));
            applyStimulus(pat[0], pat[1], {4{$urandom}}, {4{$urandom}}, 1'($urandom), 1'($urandom), 1'b0, gid);
        end
        drain();
        checkOutput("core_next_count", n_next, n_accept);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_decipher_arbiter.md
AES_DECIPHER_ARBITER -- requirements
Module: aes_decipher_arbiter

Interface
REQ-001 The block SHALL have no parameters; the requester count is fixed at 2.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  requester n has a block to decipher.
REQ-005 req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready).
REQ-006 req0_block / req1_block  in  128  ciphertext block of requester n.
REQ-007 req0_keylen / req1_keylen  in  1  0 = AES-128, 1 = AES-256.
REQ-008 rsp0_valid / rsp1_valid  out  1  result available for requester n.
REQ-009 rsp0_ready / rsp1_ready  in  1  requester n consumes the result.
REQ-010 rsp_block  out  128  plaintext result, shared by both response ports.
REQ-011 core_next  out  1  single-cycle start pulse to the decipher core.
REQ-012 core_block  out  128  block to the core, held stable for the whole operation.
REQ-013 core_keylen  out  1  keylen to the core, held stable for the whole operation.
REQ-014 core_ready  in  1  core ready flag (registered in the core; 1 when idle).
REQ-015 core_new_block  in  128  core result.
REQ-016 key_sel  out  1  selects which requester's round-key store drives the core round_key.
REQ-017 busy  out  1  1 in any state other than IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: when any req_valid=1 and core_ready=1, grant one requester, assert its req_ready for that one cycle, register its block, keylen and id (key_sel), then go to ISSUE.
REQ-020 req_ready SHALL be 0 in every state other than IDLE, and 0 for the non-granted requester.
REQ-021 ISSUE: assert core_next for exactly one cycle, then go to WAIT.
REQ-022 WAIT: ignore core_ready in the first WAIT cycle; afterwards, on core_ready=1, capture core_new_block into rsp_block and go to RESP.
REQ-023 RESP: assert rsp_valid of the granted requester only, and hold rsp_block stable until rsp_ready=1; on the handshake go to IDLE.
REQ-024 core_block, core_keylen and key_sel SHALL remain constant from ISSUE through RESP.
REQ-025 Latency: rsp_valid SHALL rise exactly 1 cycle after the core_ready rising edge observed in WAIT.
REQ-026 Changes to req inputs outside the accept cycle SHALL have no effect on an operation in flight.
REQ-027 If rsp_ready is held 0, the FSM SHALL remain in RESP indefinitely and accept no new request (back-pressure).
REQ-028 A requester whose req_valid stays high SHALL be granted again only after the current RESP handshake completes.

Reset
REQ-029 With reset=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-030 Reset values: req_ready=0, rsp_valid=0, rsp_block=0, core_next=0, core_block=0, core_keylen=0, key_sel=0, busy=0, rr pointer=0.
REQ-031 Reset mid-operation SHALL abort the operation with no response issued; the core is reset by the same system reset.

Configuration
REQ-032 Macro AES_DEC_ARB_RR_EN defined: round-robin arbitration. A 1-bit pointer names the favoured requester, starts at 0, and flips to the other requester after each grant.
REQ-033 Macro AES_DEC_ARB_RR_EN undefined: fixed priority, requester 0 always wins a simultaneous request, and the pointer logic is absent.

Verification
REQ-034 Single request, FIPS-197 C.1 vectors: req0 with block 69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0, key store 000102...0f -> rsp0_valid with rsp_block=00112233445566778899aabbccddeeff, core_next pulsed once, key_sel=0.
REQ-035 AES-256, FIPS-197 C.3 vectors: req1 with block 8ea2b7ca516745bfeafc49904b496089, keylen=1 -> rsp1_valid with rsp_block=00112233...eeff, key_sel=1, rsp0_valid=0 throughout.
REQ-036 Simultaneous requests, both valid held high for 4 operations: with RR_EN, grant order is 0,1,0,1; without RR_EN, grant order is 0,0,0,0.
REQ-037 Back-pressure: rsp_ready=0 for 20 cycles -> rsp_valid and rsp_block stable, req_ready=0, no core_next.
REQ-038 Reset asserted in WAIT -> next cycle busy=0 and rsp_valid=0; a subsequent request completes correctly.
